// File: rtl/scamp_mem_pkg.sv
// Shared definitions for the CPU/DMA memory arbiter slice.
package scamp_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } mem_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int unsigned WAIT_STATES_DEFAULT = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and DMA requesters.
module mem_arb_pick
  import scamp_mem_pkg::*;
(
  input  logic c_req,
  input  logic d_req,
  input  logic owner,
  input  logic run_limit,
  input  logic fixed_prio,
  output logic winner,
  output logic valid
);

  // Single requester always wins; ties go by mode.
  always_comb begin
    valid  = c_req | d_req;
    winner = OWNER_CPU;
    if (c_req && d_req) begin
      if (fixed_prio) begin
        // CPU is preferred until it has starved DMA for the allowed run length
        winner = run_limit ? OWNER_DMA : OWNER_CPU;
      end else begin
        winner = ~owner;
      end
    end else if (d_req) begin
      winner = OWNER_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported memory with fixed wait states.
module mem_arbiter
  import scamp_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int unsigned FIXED_PRIO  = 0,
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        c_gnt,
  output logic        d_gnt,
  output logic        c_done,
  output logic        d_done,
  output logic [15:0] c_rdata,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        owner
);

  localparam logic [3:0] RunMax   = 4'(MAX_CPU_RUN);
  localparam logic [2:0] WaitLast = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  mem_state_e  state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [3:0]  run_q, run_d;
  logic        owner_q;
  logic        lat_we_q;
  logic [15:0] lat_addr_q, lat_wdata_q;
  logic [15:0] c_rdata_q, d_rdata_q;

  logic arb_state;
  logic grant;
  logic last_access;
  logic run_limit;
  logic pick_winner;
  logic pick_valid;

  assign run_limit   = (run_q == RunMax);
  assign arb_state   = (state_q == StIdle) || (state_q == StDone);
  assign grant       = arb_state && pick_valid;
  assign last_access = ((state_q == StGrant) && (WAIT_STATES == 0)) ||
                       ((state_q == StWait) && (wait_q == WaitLast));

  mem_arb_pick u_pick (
    .c_req      (c_req),
    .d_req      (d_req),
    .owner      (owner_q),
    .run_limit  (run_limit),
    .fixed_prio (FIXED_PRIO != 0),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // FSM state, wait counter and CPU run counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wait_q  <= 3'd0;
      run_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic: arbitrate in IDLE/DONE, then GRANT, WAIT_STATES x WAIT, DONE.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle, StDone: state_d = pick_valid ? StGrant : StIdle;
      StGrant: begin
        wait_d  = 3'd0;
        state_d = (WAIT_STATES == 0) ? StDone : StWait;
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          state_d = StDone;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Run counter counts CPU grants while DMA is waiting; any DMA grant or idle DMA clears it.
  always_comb begin
    run_d = run_q;
    if (!d_req) begin
      run_d = 4'd0;
    end else if (grant) begin
      if (pick_winner == OWNER_DMA) begin
        run_d = 4'd0;
      end else if (run_q != RunMax) begin
        run_d = run_q + 4'd1;
      end
    end
  end

  // Latch the winning request at grant time and capture read data on the final access cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWNER_DMA;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 16'h0000;
      lat_wdata_q <= 16'h0000;
      c_rdata_q   <= 16'h0000;
      d_rdata_q   <= 16'h0000;
    end else begin
      if (grant) begin
        owner_q     <= pick_winner;
        lat_we_q    <= (pick_winner == OWNER_DMA) ? d_we    : c_we;
        lat_addr_q  <= (pick_winner == OWNER_DMA) ? d_addr  : c_addr;
        lat_wdata_q <= (pick_winner == OWNER_DMA) ? d_wdata : c_wdata;
      end
      if (last_access && !lat_we_q) begin
        if (owner_q == OWNER_DMA) begin
          d_rdata_q <= mem_rdata;
        end else begin
          c_rdata_q <= mem_rdata;
        end
      end
    end
  end

  // Outputs decoded from state and owner.
  always_comb begin
    mem_en    = (state_q == StGrant) || (state_q == StWait);
    mem_we    = mem_en && lat_we_q;
    mem_addr  = lat_addr_q;
    mem_wdata = lat_wdata_q;
    c_gnt     = (state_q != StIdle) && (owner_q == OWNER_CPU);
    d_gnt     = (state_q != StIdle) && (owner_q == OWNER_DMA);
    c_done    = (state_q == StDone) && (owner_q == OWNER_CPU);
    d_done    = (state_q == StDone) && (owner_q == OWNER_DMA);
    c_rdata   = c_rdata_q;
    d_rdata   = d_rdata_q;
    owner     = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut 0 = round-robin WS=1, dut 1 = fixed priority WS=1, dut 2 = round-robin WS=0.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        c_req [3], c_we [3], d_req [3], d_we [3];
  logic [15:0] c_addr [3], c_wdata [3], d_addr [3], d_wdata [3], mem_rdata [3];
  logic        c_gnt [3], d_gnt [3], c_done [3], d_done [3], mem_en [3], mem_we [3], owner [3];
  logic [15:0] c_rdata [3], d_rdata [3], mem_addr [3], mem_wdata [3];

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.WAIT_STATES(1), .FIXED_PRIO(0), .MAX_CPU_RUN(4)) u_rr (
    .clk(clk), .reset(reset),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .c_gnt(c_gnt[0]), .d_gnt(d_gnt[0]), .c_done(c_done[0]), .d_done(d_done[0]),
    .c_rdata(c_rdata[0]), .d_rdata(d_rdata[0]), .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .owner(owner[0])
  );

  mem_arbiter #(.WAIT_STATES(1), .FIXED_PRIO(1), .MAX_CPU_RUN(4)) u_fp (
    .clk(clk), .reset(reset),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .c_gnt(c_gnt[1]), .d_gnt(d_gnt[1]), .c_done(c_done[1]), .d_done(d_done[1]),
    .c_rdata(c_rdata[1]), .d_rdata(d_rdata[1]), .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .owner(owner[1])
  );

  mem_arbiter #(.WAIT_STATES(0), .FIXED_PRIO(0), .MAX_CPU_RUN(4)) u_ws0 (
    .clk(clk), .reset(reset),
    .c_req(c_req[2]), .c_we(c_we[2]), .c_addr(c_addr[2]), .c_wdata(c_wdata[2]),
    .d_req(d_req[2]), .d_we(d_we[2]), .d_addr(d_addr[2]), .d_wdata(d_wdata[2]),
    .c_gnt(c_gnt[2]), .d_gnt(d_gnt[2]), .c_done(c_done[2]), .d_done(d_done[2]),
    .c_rdata(c_rdata[2]), .d_rdata(d_rdata[2]), .mem_en(mem_en[2]), .mem_we(mem_we[2]),
    .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .mem_rdata(mem_rdata[2]),
    .owner(owner[2])
  );

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [15:0] c_addr;
    logic [15:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] rdata_in;
    logic        exp_owner;
    logic [15:0] exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_we;
    logic [15:0] exp_c_rdata;
    logic [15:0] exp_d_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = 16'h0; c_wdata[i] = 16'h0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 16'h0; d_wdata[i] = 16'h0;
      mem_rdata[i] = 16'h0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One isolated access on dut 0; inputs are scrambled right after the grant edge.
  task automatic run_vec(input int n);
    vec_t v;
    v = vecs[n];
    c_req[0] = v.c_req; c_we[0] = v.c_we; c_addr[0] = v.c_addr; c_wdata[0] = v.c_wdata;
    d_req[0] = v.d_req; d_we[0] = v.d_we; d_addr[0] = v.d_addr; d_wdata[0] = v.d_wdata;
    mem_rdata[0] = v.rdata_in;
    tick();
    chk($sformatf("v%0d grant mem_en", n), 32'(mem_en[0]), 32'd1);
    chk($sformatf("v%0d grant owner", n), 32'(owner[0]), 32'(v.exp_owner));
    chk($sformatf("v%0d grant c_gnt", n), 32'(c_gnt[0]), 32'(!v.exp_owner));
    chk($sformatf("v%0d grant d_gnt", n), 32'(d_gnt[0]), 32'(v.exp_owner));
    chk($sformatf("v%0d grant mem_addr", n), 32'(mem_addr[0]), 32'(v.exp_addr));
    chk($sformatf("v%0d grant mem_wdata", n), 32'(mem_wdata[0]), 32'(v.exp_wdata));
    chk($sformatf("v%0d grant mem_we", n), 32'(mem_we[0]), 32'(v.exp_we));
    c_req[0] = 1'b0; d_req[0] = 1'b0;
    c_addr[0] = 16'h9999; d_addr[0] = 16'h9999; c_wdata[0] = 16'h9999; d_wdata[0] = 16'h9999;
    c_we[0] = ~v.c_we; d_we[0] = ~v.d_we;
    tick();
    chk($sformatf("v%0d wait mem_en", n), 32'(mem_en[0]), 32'd1);
    chk($sformatf("v%0d wait mem_addr", n), 32'(mem_addr[0]), 32'(v.exp_addr));
    chk($sformatf("v%0d wait mem_we", n), 32'(mem_we[0]), 32'(v.exp_we));
    chk($sformatf("v%0d wait done", n), 32'(c_done[0] | d_done[0]), 32'd0);
    tick();
    chk($sformatf("v%0d done mem_en", n), 32'(mem_en[0]), 32'd0);
    chk($sformatf("v%0d done c_done", n), 32'(c_done[0]), 32'(!v.exp_owner));
    chk($sformatf("v%0d done d_done", n), 32'(d_done[0]), 32'(v.exp_owner));
    chk($sformatf("v%0d c_rdata", n), 32'(c_rdata[0]), 32'(v.exp_c_rdata));
    chk($sformatf("v%0d d_rdata", n), 32'(d_rdata[0]), 32'(v.exp_d_rdata));
    tick();
    chk($sformatf("v%0d idle gnt", n), 32'(c_gnt[0] | d_gnt[0]), 32'd0);
    chk($sformatf("v%0d idle done", n), 32'(c_done[0] | d_done[0]), 32'd0);
  endtask

  initial begin
    //          c_req we addr      wdata     d_req we addr      wdata     rd_in     own addr      wdata     we c_rdata   d_rdata
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF,
                1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h1234, 16'h00FF, 16'h5555,
                1'b1, 16'h1234, 16'h00FF, 1'b1, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1111,
                1'b0, 16'h0100, 16'h0000, 1'b0, 16'h1111, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h0300, 16'hAAAA, 1'b1, 1'b0, 16'h0400, 16'h0BAD, 16'h2222,
                1'b1, 16'h0400, 16'h0BAD, 1'b0, 16'h1111, 16'h2222};
    vecs[4] = '{1'b1, 1'b1, 16'h0500, 16'hCAFE, 1'b1, 1'b1, 16'h0600, 16'h1357, 16'h3333,
                1'b0, 16'h0500, 16'hCAFE, 1'b1, 16'h1111, 16'h2222};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h7777,
                1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h1111, 16'h7777};

    clear_inputs();
    @(negedge clk);
    // Reset state
    chk("rst mem_en", 32'(mem_en[0]), 32'd0);
    chk("rst mem_we", 32'(mem_we[0]), 32'd0);
    chk("rst gnt", 32'(c_gnt[0] | d_gnt[0]), 32'd0);
    chk("rst done", 32'(c_done[0] | d_done[0]), 32'd0);
    chk("rst mem_addr", 32'(mem_addr[0]), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata[0]), 32'd0);
    chk("rst c_rdata", 32'(c_rdata[0]), 32'd0);
    chk("rst d_rdata", 32'(d_rdata[0]), 32'd0);
    chk("rst owner", 32'(owner[0]), 32'd1);
    do_reset();

    // Table-driven single accesses, round-robin, one wait state
    for (int n = 0; n < 6; n++) run_vec(n);

    // Both held from reset: round-robin alternates with no idle cycle
    do_reset();
    c_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      int a;
      tick();
      a = (i - 1) / 3;
      chk($sformatf("rr c%0d mem_en", i), 32'(mem_en[0]), 32'(i % 3 != 0));
      chk($sformatf("rr c%0d c_gnt", i), 32'(c_gnt[0]), 32'(a % 2 == 0));
      chk($sformatf("rr c%0d d_gnt", i), 32'(d_gnt[0]), 32'(a % 2 == 1));
      chk($sformatf("rr c%0d c_done", i), 32'(c_done[0]), 32'(i % 3 == 0 && a % 2 == 0));
      chk($sformatf("rr c%0d d_done", i), 32'(d_done[0]), 32'(i % 3 == 0 && a % 2 == 1));
    end
    clear_inputs();

    // Fixed priority with starvation guard: CPU x4, DMA, CPU x4, DMA
    do_reset();
    c_req[1] = 1'b1; d_req[1] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      int a;
      tick();
      a = (i - 1) / 3;
      chk($sformatf("fp c%0d excl gnt", i), 32'(c_gnt[1] & d_gnt[1]), 32'd0);
      if (i % 3 == 1) begin
        chk($sformatf("fp a%0d d_gnt", a), 32'(d_gnt[1]), 32'(a % 5 == 4));
        chk($sformatf("fp a%0d c_gnt", a), 32'(c_gnt[1]), 32'(a % 5 != 4));
      end
    end
    clear_inputs();

    // Zero wait states: one mem_en cycle, done two cycles after the request edge
    do_reset();
    c_req[2] = 1'b1; c_addr[2] = 16'h0042; mem_rdata[2] = 16'hA5A5;
    tick();
    chk("ws0 grant mem_en", 32'(mem_en[2]), 32'd1);
    chk("ws0 grant mem_addr", 32'(mem_addr[2]), 32'h0042);
    chk("ws0 grant c_done", 32'(c_done[2]), 32'd0);
    c_req[2] = 1'b0;
    tick();
    chk("ws0 done mem_en", 32'(mem_en[2]), 32'd0);
    chk("ws0 done c_done", 32'(c_done[2]), 32'd1);
    chk("ws0 c_rdata", 32'(c_rdata[2]), 32'hA5A5);
    tick();
    chk("ws0 idle c_done", 32'(c_done[2]), 32'd0);
    chk("ws0 idle c_gnt", 32'(c_gnt[2]), 32'd0);
    clear_inputs();

    // Reset during WAIT abandons the access; a fresh access follows release
    do_reset();
    c_req[0] = 1'b1; c_addr[0] = 16'h0077; mem_rdata[0] = 16'h4321;
    tick();
    tick();
    chk("mid wait mem_en", 32'(mem_en[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid rst mem_en", 32'(mem_en[0]), 32'd0);
    chk("mid rst c_gnt", 32'(c_gnt[0]), 32'd0);
    chk("mid rst c_done", 32'(c_done[0]), 32'd0);
    chk("mid rst mem_addr", 32'(mem_addr[0]), 32'd0);
    chk("mid rst owner", 32'(owner[0]), 32'd1);
    tick();
    chk("mid rst no done", 32'(c_done[0]), 32'd0);
    reset = 1'b0;
    tick();
    chk("post rst c_gnt", 32'(c_gnt[0]), 32'd1);
    chk("post rst mem_addr", 32'(mem_addr[0]), 32'h0077);
    tick();
    chk("post rst wait done", 32'(c_done[0]), 32'd0);
    tick();
    chk("post rst c_done", 32'(c_done[0]), 32'd1);
    chk("post rst c_rdata", 32'(c_rdata[0]), 32'h4321);
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
